// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline hold/flush controller. Merges stall and redirect
//             requests into one nested hold code, forwards jump redirects,
//             stretches the IF/ID squash after a jump and sequences the
//             debug drain/halt/resume handshake.
//  Options  : PIPE_CTRL_PERF_EN - enables the stall-cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int unsigned FLUSH_EXT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_rib_i,
  input  logic        hold_flag_clint_i,
  input  logic        jtag_halt_req_i,
  input  logic        perf_clr_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        jtag_halted_o,
  output logic [31:0] stall_cycles_o
);

  localparam logic [2:0] C_HOLD_NONE = 3'b000;
  localparam logic [2:0] C_HOLD_PC   = 3'b001;
  localparam logic [2:0] C_HOLD_IFID = 3'b010;
  localparam logic [2:0] C_HOLD_ALL  = 3'b011;
  localparam logic [2:0] C_FLUSH_LD  = 3'(FLUSH_EXT);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] flush_q, flush_d;
  logic       quiet;
  logic [2:0] hold_code;

  // Pipeline is quiet when no source is requesting a hold and no squash is pending.
  assign quiet = !jump_flag_i && !hold_flag_ex_i && !hold_flag_rib_i &&
                 !hold_flag_clint_i && (flush_q == 3'd0);

  // State and flush-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      flush_q <= 3'd0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic for the debug handshake and the post-jump flush counter.
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    if (jump_flag_i) begin
      flush_d = C_FLUSH_LD;
    end else if (flush_q != 3'd0) begin
      flush_d = flush_q - 3'd1;
    end
    case (state_q)
      ST_RUN: begin
        if (jtag_halt_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!jtag_halt_req_i) state_d = ST_RUN;
        else if (quiet)       state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!jtag_halt_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Hold code is the largest active contribution; codes are nested supersets.
  always_comb begin
    hold_code = C_HOLD_NONE;
    if (hold_flag_rib_i || (state_q == ST_DRAIN)) hold_code = C_HOLD_PC;
    if (flush_q != 3'd0)                          hold_code = C_HOLD_IFID;
    if (jump_flag_i || hold_flag_ex_i || hold_flag_clint_i || (state_q == ST_HALTED))
      hold_code = C_HOLD_ALL;
    if (rst) hold_code = C_HOLD_NONE;
  end

  assign hold_flag_o   = hold_code;
  assign jump_flag_o   = jump_flag_i && !rst;
  assign jump_addr_o   = (jump_flag_i && !rst) ? jump_addr_i : 32'h0;
  assign jtag_halted_o = (state_q == ST_HALTED) && !rst;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;

  // Stall-cycle counter; clear wins over increment, halted cycles are not stalls.
  always_ff @(posedge clk) begin
    if (rst || perf_clr_i) begin
      stall_q <= 32'h0;
    end else if ((hold_code != C_HOLD_NONE) && (state_q != ST_HALTED)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = rst ? 32'h0 : stall_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign stall_cycles_o  = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Scoreboard bench for pipe_ctrl: directed scenarios followed by
//             random traffic, checked against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int unsigned FE = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_flag_ex_i = 1'b0;
  logic        hold_flag_rib_i = 1'b0;
  logic        hold_flag_clint_i = 1'b0;
  logic        jtag_halt_req_i = 1'b0;
  logic        perf_clr_i = 1'b0;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        jtag_halted_o;
  logic [31:0] stall_cycles_o;

  pipe_ctrl #(.FLUSH_EXT(FE)) dut (
    .clk               (clk),
    .rst               (rst),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i),
    .hold_flag_ex_i    (hold_flag_ex_i),
    .hold_flag_rib_i   (hold_flag_rib_i),
    .hold_flag_clint_i (hold_flag_clint_i),
    .jtag_halt_req_i   (jtag_halt_req_i),
    .perf_clr_i        (perf_clr_i),
    .hold_flag_o       (hold_flag_o),
    .jump_flag_o       (jump_flag_o),
    .jump_addr_o       (jump_addr_o),
    .jtag_halted_o     (jtag_halted_o),
    .stall_cycles_o    (stall_cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          hold;
    bit          jf;
    logic [31:0] ja;
    bit          halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural model: mode 0=running, 1=draining, 2=halted.
  int          m_mode = 0;
  int          m_flush = 0;
  logic [31:0] m_cnt = 32'h0;
  bit          preload_pending = 1'b0;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // One stimulus cycle: drive inputs, push expected outputs, advance the model.
  task automatic step(input bit r, input bit jf, input logic [31:0] ja,
                      input bit ex, input bit rib, input bit clint,
                      input bit req, input bit clr);
    exp_t e;
    int   h;
    bit   quiet;
    @(posedge clk);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    if (preload_pending) begin
      dut.stall_q = 32'hFFFF_FFFE;
      m_cnt = 32'hFFFF_FFFE;
      preload_pending = 1'b0;
    end
`endif
    rst = r; jump_flag_i = jf; jump_addr_i = ja; hold_flag_ex_i = ex;
    hold_flag_rib_i = rib; hold_flag_clint_i = clint;
    jtag_halt_req_i = req; perf_clr_i = clr;
    if (r) begin
      e.hold = 0; e.jf = 0; e.ja = 32'h0; e.halted = 0; e.cnt = 32'h0;
      sb.push_back(e);
      m_mode = 0; m_flush = 0; m_cnt = 32'h0;
      return;
    end
    h = 0;
    if (rib || m_mode == 1) h = max2(h, 1);
    if (m_flush != 0)       h = max2(h, 2);
    if (jf || ex || clint || m_mode == 2) h = max2(h, 3);
    e.hold = h; e.jf = jf; e.ja = jf ? ja : 32'h0; e.halted = (m_mode == 2);
`ifdef PIPE_CTRL_PERF_EN
    e.cnt = m_cnt;
    if (clr) m_cnt = 32'h0;
    else if (h != 0 && m_mode != 2) m_cnt = m_cnt + 32'd1;
`else
    e.cnt = 32'h0;
`endif
    sb.push_back(e);
    quiet = !jf && !ex && !rib && !clint && (m_flush == 0);
    if (m_mode == 0)      m_mode = req ? 1 : 0;
    else if (m_mode == 1) m_mode = !req ? 0 : (quiet ? 2 : 1);
    else                  m_mode = req ? 2 : 0;
    m_flush = jf ? int'(FE) : ((m_flush > 0) ? m_flush - 1 : 0);
  endtask

  task automatic idle(input bit req);
    step(0, 0, 32'hDEAD_BEEF, 0, 0, 0, req, 0);
  endtask

  // Monitor: compares every cycle the DUT presents outputs for a queued entry.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (int'(hold_flag_o) != e.hold) begin
        n_errors++; $display("FAIL hold: got %0d expected %0d at %0t", hold_flag_o, e.hold, $time);
      end
      n_checks++;
      if (jump_flag_o !== e.jf) begin
        n_errors++; $display("FAIL jump_flag: got %0b expected %0b at %0t", jump_flag_o, e.jf, $time);
      end
      n_checks++;
      if (jump_addr_o !== e.ja) begin
        n_errors++; $display("FAIL jump_addr: got %h expected %h at %0t", jump_addr_o, e.ja, $time);
      end
      n_checks++;
      if (jtag_halted_o !== e.halted) begin
        n_errors++; $display("FAIL halted: got %0b expected %0b at %0t", jtag_halted_o, e.halted, $time);
      end
      n_checks++;
      if (stall_cycles_o !== e.cnt) begin
        n_errors++; $display("FAIL stall_cycles: got %h expected %h at %0t", stall_cycles_o, e.cnt, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit req_lvl;
    // Reset
    step(1, 0, 32'h0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h55, 1, 1, 1, 1, 1);
    idle(0);
    // Single jump, then back-to-back jumps
    step(0, 1, 32'h0000_0100, 0, 0, 0, 0, 0);
    idle(0); idle(0);
    step(0, 1, 32'h0000_0200, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0300, 0, 0, 0, 0, 0);
    idle(0); idle(0);
    // Priority: rib+ex, rib alone, nothing; jump with rib
    step(0, 0, 32'h0, 1, 1, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 0, 0, 0);
    idle(0);
    step(0, 1, 32'h0000_0400, 0, 1, 0, 0, 0);
    idle(0); idle(0);
    // Halt with busy execute, then resume
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0, 0, 1, 0);
    idle(1); idle(1); idle(1);
    idle(0); idle(0);
    // Halt abort, toggling request, reset while halted
    idle(1); idle(0); idle(0);
    idle(1); idle(0); idle(1); idle(0);
    idle(1); idle(1); idle(1);
    step(1, 0, 32'h0, 0, 0, 0, 1, 0);
    idle(0);
    // Perf counter: four stalls, clear during a stall, forced wrap
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 1, 0, 0, 0);
    idle(0);
    step(0, 0, 32'h0, 0, 1, 0, 0, 1);
    idle(0);
    preload_pending = 1'b1;
    step(0, 0, 32'h0, 0, 1, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 0, 0, 0);
    idle(0); idle(0);
    // Random traffic
    req_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) req_lvl = ~req_lvl;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 12, $urandom,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 5, req_lvl,
           $urandom_range(0, 99) < 3);
    end
    idle(0);
    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
